// File: rtl/tetris_audio_engine.sv
// Tetris-style square-wave audio: looping melody table plus a single-slot, priority-preempting
// sound-effect channel. Define TETRIS_AUDIO_LEVEL_TEMPO_EN to shorten notes as the game level rises.
module tetris_audio_engine #(
  parameter int CNT_W     = 32,
  parameter int NUM_NOTES = 16,
  parameter int NUM_SFX   = 4,
  parameter int TEMPO     = 25000000,
  parameter int SFX_TIME  = 10000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         play,
  input  logic [NUM_SFX-1:0]           sfx_trig,
  input  logic [NUM_SFX*CNT_W-1:0]     sfx_period,
  input  logic                         note_wr,
  input  logic [$clog2(NUM_NOTES)-1:0] note_addr,
  input  logic [CNT_W-1:0]             note_data,
  input  logic [3:0]                   level,
  output logic                         audio_out,
  output logic [$clog2(NUM_NOTES)-1:0] note_index,
  output logic [NUM_SFX-1:0]           sfx_active
);

  localparam int NI_W = $clog2(NUM_NOTES);
  localparam int CH_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

  // Identity of whatever is driving the tone generator; any change restarts the waveform.
  typedef struct packed {
    logic            sfx;
    logic [CH_W-1:0] ch;
    logic            play;
    logic [NI_W-1:0] note;
  } src_t;

  // NOTE: the melody table has no reset; clearing a RAM costs a mux per bit and the
  // table is defined to survive reset.
  logic [CNT_W-1:0] mem_q [NUM_NOTES];

  always_ff @(posedge clk) begin
    if (note_wr) mem_q[note_addr] <= note_data;
  end

  logic [CNT_W-1:0] sfx_per [NUM_SFX];
  for (genvar g = 0; g < NUM_SFX; g++) begin : g_per
    assign sfx_per[g] = sfx_period[g*CNT_W +: CNT_W];
  end

  logic [CNT_W-1:0]   tempo_q, tempo_d;
  logic [NI_W-1:0]    note_index_q, note_index_d;
  logic [NUM_SFX-1:0] trig_q, trig_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  src_t               src_q, src_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic               audio_q, audio_d;
  logic [CNT_W-1:0]   note_len;
  logic               tempo_wrap;

`ifdef TETRIS_AUDIO_LEVEL_TEMPO_EN
  logic [3:0] level_q, level_d;
  assign note_len = CNT_W'(TEMPO) - CNT_W'(level_q) * CNT_W'(TEMPO >> 4);
`else
  logic unused_level;
  assign unused_level = ^level;
  assign note_len     = CNT_W'(TEMPO);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tempo_d      = tempo_q;
    note_index_d = note_index_q;
    tempo_wrap   = 1'b0;
    if (play) begin
      // >= rather than == so a shrinking note length never strands the counter past the end.
      if (tempo_q >= note_len - CNT_W'(1)) begin
        tempo_wrap   = 1'b1;
        tempo_d      = '0;
        note_index_d = note_index_q + NI_W'(1);
      end else begin
        tempo_d = tempo_q + CNT_W'(1);
      end
    end
  end

`ifdef TETRIS_AUDIO_LEVEL_TEMPO_EN
  always_comb begin
    level_d = level_q;
    if (tempo_wrap) level_d = level;
  end
`endif

  logic [NUM_SFX-1:0] new_trig;
  logic               trig_any, busy_q, sfx_start;
  logic [CH_W-1:0]    trig_ch;

  always_comb begin
    trig_d   = sfx_trig;
    new_trig = sfx_trig & ~trig_q;
    trig_any = 1'b0;
    trig_ch  = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (new_trig[i]) begin
        trig_any = 1'b1;
        trig_ch  = CH_W'(i);
      end
    end
    busy_q    = (timer_q != '0);
    sfx_start = trig_any && (!busy_q || trig_ch >= ch_q);
    ch_d      = ch_q;
    timer_d   = busy_q ? timer_q - CNT_W'(1) : '0;
    if (sfx_start) begin
      ch_d    = trig_ch;
      timer_d = CNT_W'(SFX_TIME);
    end
  end

  logic [CNT_W-1:0] per_sel;

  always_comb begin
    src_d      = '0;
    src_d.sfx  = (timer_d != '0);
    src_d.ch   = src_d.sfx ? ch_d : '0;
    src_d.play = !src_d.sfx && play;
    src_d.note = src_d.play ? note_index_d : '0;

    if (src_d.sfx)       per_sel = sfx_per[ch_d];
    else if (src_d.play) per_sel = mem_q[note_index_d];
    else                 per_sel = '0;

    phase_d = phase_q + CNT_W'(1);
    per_d   = per_q;
    // A rest or degenerate period wraps every cycle so a new source period is picked up promptly.
    if (src_d != src_q || sfx_start || per_q <= CNT_W'(1) || phase_q >= per_q - CNT_W'(1)) begin
      phase_d = '0;
      per_d   = per_sel;
    end
    audio_d = (per_d > CNT_W'(1)) && (phase_d < (per_d >> 1));
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tempo_q      <= '0;
      note_index_q <= '0;
      trig_q       <= '1;
      timer_q      <= '0;
      ch_q         <= '0;
      src_q        <= '0;
      phase_q      <= '0;
      per_q        <= '0;
      audio_q      <= 1'b0;
`ifdef TETRIS_AUDIO_LEVEL_TEMPO_EN
      level_q      <= '0;
`endif
    end else begin
      tempo_q      <= tempo_d;
      note_index_q <= note_index_d;
      trig_q       <= trig_d;
      timer_q      <= timer_d;
      ch_q         <= ch_d;
      src_q        <= src_d;
      phase_q      <= phase_d;
      per_q        <= per_d;
      audio_q      <= audio_d;
`ifdef TETRIS_AUDIO_LEVEL_TEMPO_EN
      level_q      <= level_d;
`endif
    end
  end

  assign audio_out  = audio_q;
  assign note_index = note_index_q;
  assign sfx_active = busy_q ? (NUM_SFX'(1) << ch_q) : '0;

endmodule

// File: doc/tetris_audio_engine.md
TETRIS_AUDIO_ENGINE -- requirements
Module: tetris_audio_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CNT_W, 32, width of every period and timer counter.
REQ-002 NUM_NOTES, 16, melody table depth; power of two, >= 2.
REQ-003 NUM_SFX, 4, number of sound-effect channels, >= 1.
REQ-004 TEMPO, 25000000, cycles per melody note.
REQ-005 SFX_TIME, 10000000, cycles a sound effect sounds.
REQ-006 Ports SHALL be (name direction width meaning): clk  in  1  single clock, all state on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 play  in  1  melody enable; 0 pauses and silences the melody.
REQ-009 sfx_trig  in  NUM_SFX  per-channel trigger; rising-edge sensitive.
REQ-010 sfx_period  in  NUM_SFX*CNT_W  tone period per channel; channel i occupies bits [i*CNT_W +: CNT_W]; static.
REQ-011 note_wr, note_addr, note_data  in  1, log2(NUM_NOTES), CNT_W  melody table write port.
REQ-012 level  in  4  game level; used only under REQ-030.
REQ-013 audio_out  out  1  registered square-wave output.
REQ-014 note_index  out  log2(NUM_NOTES)  current melody step.
REQ-015 sfx_active  out  NUM_SFX  one-hot channel now sounding; all zero when none.

Function
REQ-016 Melody table SHALL be NUM_NOTES x CNT_W; a write on note_wr=1 at edge k SHALL be readable from edge k+1; table is not cleared by reset.
REQ-017 Tempo counter SHALL count 0..TEMPO-1 while play=1, wrap to 0 and advance note_index modulo NUM_NOTES (NUM_NOTES-1 -> 0) on the wrap cycle; while play=0 counter and note_index SHALL hold.
REQ-018 Edge detector SHALL register sfx_trig each cycle; a channel starts at the first edge where sfx_trig[i]=1 and its registered copy is 0; sfx_active is visible after that same edge.
REQ-019 One SFX slot SHALL exist; higher channel index = higher priority; simultaneous new triggers resolve to the highest index.
REQ-020 A new trigger SHALL preempt the slot if idle or its index >= the sounding index (same index restarts the timer); lower-index triggers while busy SHALL be dropped, not queued.
REQ-021 On start the SFX timer SHALL load SFX_TIME and decrement each cycle; the slot is busy while timer != 0, giving exactly SFX_TIME busy cycles.
REQ-022 Source select: busy SFX -> sfx_period of its channel; else play=1 -> melody entry at note_index; else silence.
REQ-023 Tone generator: phase counter 0..P-1; audio_out=1 while phase < P>>1, else 0; P latched when the phase wraps.
REQ-024 On a source change (note advance, SFX start/preempt/end, play toggle) phase SHALL reset to 0 and P reload on that edge.
REQ-025 P=0 (rest) or P=1 SHALL hold audio_out=0.
REQ-026 SFX SHALL sound regardless of play.

Reset
REQ-027 reset_n=0 SHALL immediately force audio_out=0, note_index=0, sfx_active=0, all counters and timers 0.
REQ-028 Registered sfx_trig copies SHALL reset to all ones, so triggers held high through reset do not fire.
REQ-029 Reset assertion mid-note or mid-SFX SHALL abort it; after release the melody restarts at step 0.

Configuration
REQ-030 With TETRIS_AUDIO_LEVEL_TEMPO_EN defined, note length SHALL be TEMPO - level*(TEMPO>>4) cycles, level sampled at each tempo wrap; undefined, level is ignored and note length is TEMPO.

Verification (CNT_W=16, NUM_NOTES=4, NUM_SFX=2, TEMPO=20, SFX_TIME=12)
REQ-031 Write table 8,4,0,6, play=1 -> 20 cycles of 4-high/4-low, 20 cycles 2-high/2-low, 20 cycles low, 20 cycles 3-high/3-low, note_index 3 -> 0.
REQ-032 sfx_period={10,6}; pulse ch0, ch1 three cycles later -> sfx_active 01 then 10 for 12 cycles at period 10; ch0 pulse during ch1 ignored; then melody resumes.
REQ-033 ch0 and ch1 rise on the same edge -> sfx_active=10, 12 cycles.
REQ-034 play=0 mid-note -> note_index holds, audio_out 0; ch0 pulse -> 12 cycles of period 6 tone.
REQ-035 reset_n low mid-SFX -> audio_out, sfx_active 0 without clock; sfx_trig held high across release -> no SFX.
REQ-036 TETRIS_AUDIO_LEVEL_TEMPO_EN, level=8 -> note length 12 cycles (20 - 8*1).
